rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 85 ++++++++
 tb/tb_rom_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter sharing a single registered-read ROM port between
// instruction fetch (IF) and load (LD) requesters; one read in flight at a time.
module rom_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    output logic              if_rsp_err,
    input  logic              if_rsp_ready,

    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_rsp_valid,
    output logic [31:0]       ld_rsp_data,
    output logic              ld_rsp_err,
    input  logic              ld_rsp_ready,

    output logic [ADDR_W-1:0] rom_address,
    input  logic [31:0]       rom_data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LD = 1'b1;

    logic [0:0]        state;
    logic              grant_p1;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_p1;
    logic              err_p1;

    logic              rsp_fire;
    logic              can_accept;
    logic              if_acc;
    logic              ld_acc;
    logic [ADDR_W-1:0] sel_addr;

    // Ready is gated by reset_n so both requesters see ready drop the moment reset asserts.
    always_comb begin
        rsp_fire     = (state == RESP) && ((grant_p1 == GNT_IF) ? if_rsp_ready : ld_rsp_ready);
        can_accept   = reset_n && ((state == IDLE) || rsp_fire);
        if_req_ready = can_accept && (!ld_req_valid || (last_grant == GNT_LD));
        ld_req_ready = can_accept && (!if_req_valid || (last_grant == GNT_IF));
        if_acc       = if_req_valid && if_req_ready;
        ld_acc       = ld_req_valid && ld_req_ready;
        sel_addr     = ld_acc ? ld_req_addr : if_req_addr;
        rom_address  = (if_acc || ld_acc) ? sel_addr : addr_p1;
    end

    // ---- stage p1: accepted request, response presented from the ROM's registered read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_p1   <= GNT_IF;
            last_grant <= GNT_LD;
            addr_p1    <= '0;
            err_p1     <= 1'b0;
        end else if (if_acc || ld_acc) begin
            state      <= RESP;
            grant_p1   <= ld_acc;
            last_grant <= ld_acc;
            addr_p1    <= sel_addr;
            err_p1     <= |sel_addr[1:0];
        end else if (rsp_fire) begin
            state      <= IDLE;
        end
    end

    assign if_rsp_valid = (state == RESP) && (grant_p1 == GNT_IF);
    assign ld_rsp_valid = (state == RESP) && (grant_p1 == GNT_LD);
    assign if_rsp_data  = rom_data;
    assign ld_rsp_data  = rom_data;
    assign if_rsp_err   = if_rsp_valid && err_p1;
    assign ld_rsp_err   = ld_rsp_valid && err_p1;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: drivers push expected responses on acceptance,
// a negedge monitor pops and compares every response handshake.
module tb_rom_arbiter;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              if_req_valid = 1'b0;
    logic [ADDR_W-1:0] if_req_addr = '0;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              if_rsp_err;
    logic              if_rsp_ready = 1'b1;
    logic              ld_req_valid = 1'b0;
    logic [ADDR_W-1:0] ld_req_addr = '0;
    logic              ld_req_ready;
    logic              ld_rsp_valid;
    logic [31:0]       ld_rsp_data;
    logic              ld_rsp_err;
    logic              ld_rsp_ready = 1'b1;
    logic [ADDR_W-1:0] rom_address;
    logic [31:0]       rom_data;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .if_rsp_ready (if_rsp_ready),
        .ld_req_valid (ld_req_valid),
        .ld_req_addr  (ld_req_addr),
        .ld_req_ready (ld_req_ready),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data),
        .ld_rsp_err   (ld_rsp_err),
        .ld_rsp_ready (ld_rsp_ready),
        .rom_address  (rom_address),
        .rom_data     (rom_data)
    );

    // ROM with registered read: word[i] = A000_0000 | i*0001_0101 (no carries for small i)
    logic [31:0] rom_q;
    always @(posedge clk) rom_q <= 32'hA000_0000 | ({26'd0, rom_address[7:2]} * 32'h0001_0101);
    assign rom_data = rom_q;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    bit   acc_port[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rsp_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // port 0 = IF, 1 = LD
    task automatic send(input bit port, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input bit e);
        int n = 0;
        if (port) begin ld_req_valid = 1'b1; ld_req_addr = a; end
        else      begin if_req_valid = 1'b1; if_req_addr = a; end
        #1;
        while (!(port ? ld_req_ready : if_req_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (port ? ld_req_ready : if_req_ready) begin
            check($sformatf("%s_accept_addr", port ? "ld" : "if"),
                  {16'd0, rom_address}, {16'd0, a});
            exp_q.push_back('{port, d, e});
            acc_port.push_back(port);
            acc_cyc.push_back(cyc);
            @(posedge clk); #1;
        end else begin
            n_tests++; n_fail++;
            $display("FAIL %s_accept_timeout: ready stayed 0 for addr %h",
                     port ? "ld" : "if", a);
        end
        if (port) ld_req_valid = 1'b0; else if_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk); #2; n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every response handshake must match the next expected entry
    always @(negedge clk) begin
        exp_t e;
        bit   p;
        if (reset_n) begin
            if (if_rsp_valid && ld_rsp_valid) begin
                n_tests++; n_fail++;
                $display("FAIL both_rsp_valid: got 1/1 expected one-hot");
            end
            if ((if_rsp_valid && if_rsp_ready) || (ld_rsp_valid && ld_rsp_ready)) begin
                rsp_seen++;
                p = ld_rsp_valid;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: port %0d data %h with nothing expected",
                             p, p ? ld_rsp_data : if_rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_port", 32'(p), 32'(e.port));
                    check("rsp_data", p ? ld_rsp_data : if_rsp_data, e.data);
                    check("rsp_err", 32'(p ? ld_rsp_err : if_rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_before;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_if_req_ready", 32'(if_req_ready), 0);
        check("rst_ld_req_ready", 32'(ld_req_ready), 0);
        check("rst_if_rsp_valid", 32'(if_rsp_valid), 0);
        check("rst_ld_rsp_valid", 32'(ld_rsp_valid), 0);
        check("rst_if_rsp_err", 32'(if_rsp_err), 0);
        check("rst_rom_address", {16'd0, rom_address}, 0);
        reset_n = 1'b1;

        // Tie in first cycle after reset: IF first, LD on IF response fire
        acc_cyc.delete(); acc_port.delete();
        fork
            send(1'b0, 16'h0000, 32'hA000_0000, 1'b0);
            send(1'b1, 16'h0010, 32'hA004_0404, 1'b0);
        join
        drain();
        check("tie_first_port", 32'(acc_port[0]), 0);
        check("tie_gap_cycles", acc_cyc[1] - acc_cyc[0], 1);

        // Single IF read with latency-1 response
        send(1'b0, 16'h0008, 32'hA002_0202, 1'b0);
        check("if_latency1_valid", 32'(if_rsp_valid), 1);
        drain();

        // LD read under backpressure
        ld_rsp_ready = 1'b0;
        send(1'b1, 16'h0004, 32'hA001_0101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stall_ld_rsp_valid", 32'(ld_rsp_valid), 1);
            check("stall_ld_rsp_data", ld_rsp_data, 32'hA001_0101);
            check("stall_rom_address", {16'd0, rom_address}, 32'h0004);
            check("stall_if_req_ready", 32'(if_req_ready), 0);
            check("stall_ld_req_ready", 32'(ld_req_ready), 0);
        end
        @(posedge clk); #1;
        ld_rsp_ready = 1'b1;
        drain();

        // Misaligned LD address
        send(1'b1, 16'h0006, 32'hA001_0101, 1'b1);
        drain();

        // Both ports continuously valid: strict alternation, one per cycle
        acc_cyc.delete(); acc_port.delete();
        fork
            for (int i = 0; i < 4; i++)
                send(1'b0, 16'(4 * i), 32'hA000_0000 | (32'(i) * 32'h0001_0101), 1'b0);
            for (int j = 0; j < 4; j++)
                send(1'b1, 16'(16 + 4 * j), 32'hA000_0000 | (32'(4 + j) * 32'h0001_0101), 1'b0);
        join
        drain();
        check("alt_count", acc_port.size(), 8);
        if (acc_port.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("alt_port", 32'(acc_port[k]), 32'(k % 2));
                check("alt_cycle", acc_cyc[k] - acc_cyc[0], k);
            end
        end

        // Reset asserted mid-response
        if_rsp_ready = 1'b0;
        send(1'b0, 16'h000C, 32'hA003_0303, 1'b0);
        @(negedge clk); #1;
        check("pre_rst_if_rsp_valid", 32'(if_rsp_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_if_rsp_valid", 32'(if_rsp_valid), 0);
        check("async_rst_if_req_ready", 32'(if_req_ready), 0);
        check("async_rst_ld_req_ready", 32'(ld_req_ready), 0);
        check("async_rst_rom_address", {16'd0, rom_address}, 0);
        exp_q.delete();
        seen_before = rsp_seen;
        if_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check("no_stale_rsp", rsp_seen - seen_before, 0);

        // Traffic resumes after reset; misaligned IF address
        send(1'b0, 16'h0016, 32'hA005_0505, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
